// File: rtl/dccm_port_arb_if.sv
// rtl/dccm_port_arb_if.sv - requester and DCCM signal bundle for the DCCM port arbiter
interface dccm_port_arb_if #(
    parameter int DCCM_BITS   = 16,
    parameter int FDATA_WIDTH = 39
);
    logic                   lsu_valid;
    logic                   lsu_wr;
    logic [DCCM_BITS-1:0]   lsu_addr_lo;
    logic [DCCM_BITS-1:0]   lsu_addr_hi;
    logic [FDATA_WIDTH-1:0] lsu_wdata;
    logic                   lsu_ready;
    logic                   lsu_rsp_valid;

    logic                   dma_valid;
    logic                   dma_wr;
    logic [DCCM_BITS-1:0]   dma_addr;
    logic [FDATA_WIDTH-1:0] dma_wdata;
    logic                   dma_ready;
    logic                   dma_rsp_valid;

    logic                   dbg_valid;
    logic                   dbg_wr;
    logic [DCCM_BITS-1:0]   dbg_addr;
    logic [FDATA_WIDTH-1:0] dbg_wdata;
    logic                   dbg_ready;
    logic                   dbg_rsp_valid;

    logic                   dccm_wren;
    logic                   dccm_rden;
    logic [DCCM_BITS-1:0]   dccm_wr_addr;
    logic [DCCM_BITS-1:0]   dccm_rd_addr_lo;
    logic [DCCM_BITS-1:0]   dccm_rd_addr_hi;
    logic [FDATA_WIDTH-1:0] dccm_wr_data;
    logic [FDATA_WIDTH-1:0] dccm_rd_data_lo;
    logic [FDATA_WIDTH-1:0] dccm_rd_data_hi;
    logic [FDATA_WIDTH-1:0] rsp_data_lo;
    logic [FDATA_WIDTH-1:0] rsp_data_hi;

    modport slave (
        input  lsu_valid, lsu_wr, lsu_addr_lo, lsu_addr_hi, lsu_wdata,
        input  dma_valid, dma_wr, dma_addr, dma_wdata,
        input  dbg_valid, dbg_wr, dbg_addr, dbg_wdata,
        input  dccm_rd_data_lo, dccm_rd_data_hi,
        output lsu_ready, dma_ready, dbg_ready,
        output lsu_rsp_valid, dma_rsp_valid, dbg_rsp_valid,
        output dccm_wren, dccm_rden, dccm_wr_addr, dccm_rd_addr_lo, dccm_rd_addr_hi,
        output dccm_wr_data, rsp_data_lo, rsp_data_hi
    );

    modport master (
        output lsu_valid, lsu_wr, lsu_addr_lo, lsu_addr_hi, lsu_wdata,
        output dma_valid, dma_wr, dma_addr, dma_wdata,
        output dbg_valid, dbg_wr, dbg_addr, dbg_wdata,
        output dccm_rd_data_lo, dccm_rd_data_hi,
        input  lsu_ready, dma_ready, dbg_ready,
        input  lsu_rsp_valid, dma_rsp_valid, dbg_rsp_valid,
        input  dccm_wren, dccm_rden, dccm_wr_addr, dccm_rd_addr_lo, dccm_rd_addr_hi,
        input  dccm_wr_data, rsp_data_lo, rsp_data_hi
    );
endinterface

// File: rtl/dccm_port_arb.sv
// rtl/dccm_port_arb.sv - LSU/DMA/DBG arbiter for the single DCCM port; DCCM_PORT_ARB_PERF_EN adds a conflict counter
module dccm_port_arb #(
    parameter int DCCM_BITS   = 16,
    parameter int FDATA_WIDTH = 39,
    parameter int STARVE_MAX  = 4
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    dccm_port_arb_if.slave        bus
`ifdef DCCM_PORT_ARB_PERF_EN
    ,
    output logic [15:0]           o_perf_conflict_cnt
`endif
);
    typedef enum logic [1:0] {OWN_NONE, OWN_LSU, OWN_DMA, OWN_DBG} owner_e;

    localparam logic [3:0] C_STARVE = 4'(STARVE_MAX);

    owner_e w_grant;
    owner_e w_owner_nxt;
    owner_e r_owner;
    logic [3:0] r_dma_cnt;
    logic [3:0] r_dbg_cnt;

    // Saturated starvation counters override the fixed LSU > DMA > DBG order.
    always_comb begin
        w_grant = OWN_NONE;
        if (!i_rst) begin
            if (bus.dma_valid && r_dma_cnt == C_STARVE)      w_grant = OWN_DMA;
            else if (bus.dbg_valid && r_dbg_cnt == C_STARVE) w_grant = OWN_DBG;
            else if (bus.lsu_valid)                          w_grant = OWN_LSU;
            else if (bus.dma_valid)                          w_grant = OWN_DMA;
            else if (bus.dbg_valid)                          w_grant = OWN_DBG;
        end
    end

    always_comb begin
        bus.lsu_ready       = 1'b0;
        bus.dma_ready       = 1'b0;
        bus.dbg_ready       = 1'b0;
        bus.dccm_wren       = 1'b0;
        bus.dccm_rden       = 1'b0;
        bus.dccm_wr_addr    = '0;
        bus.dccm_rd_addr_lo = '0;
        bus.dccm_rd_addr_hi = '0;
        bus.dccm_wr_data    = '0;
        w_owner_nxt         = OWN_NONE;
        case (w_grant)
            OWN_LSU: begin
                bus.lsu_ready = 1'b1;
                if (bus.lsu_wr) begin
                    bus.dccm_wren    = 1'b1;
                    bus.dccm_wr_addr = bus.lsu_addr_lo;
                    bus.dccm_wr_data = bus.lsu_wdata;
                end else begin
                    bus.dccm_rden       = 1'b1;
                    bus.dccm_rd_addr_lo = bus.lsu_addr_lo;
                    bus.dccm_rd_addr_hi = bus.lsu_addr_hi;
                    w_owner_nxt         = OWN_LSU;
                end
            end
            OWN_DMA: begin
                bus.dma_ready = 1'b1;
                if (bus.dma_wr) begin
                    bus.dccm_wren    = 1'b1;
                    bus.dccm_wr_addr = bus.dma_addr;
                    bus.dccm_wr_data = bus.dma_wdata;
                end else begin
                    bus.dccm_rden       = 1'b1;
                    bus.dccm_rd_addr_lo = bus.dma_addr;
                    bus.dccm_rd_addr_hi = bus.dma_addr;
                    w_owner_nxt         = OWN_DMA;
                end
            end
            OWN_DBG: begin
                bus.dbg_ready = 1'b1;
                if (bus.dbg_wr) begin
                    bus.dccm_wren    = 1'b1;
                    bus.dccm_wr_addr = bus.dbg_addr;
                    bus.dccm_wr_data = bus.dbg_wdata;
                end else begin
                    bus.dccm_rden       = 1'b1;
                    bus.dccm_rd_addr_lo = bus.dbg_addr;
                    bus.dccm_rd_addr_hi = bus.dbg_addr;
                    w_owner_nxt         = OWN_DBG;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) r_owner <= OWN_NONE;
        else       r_owner <= w_owner_nxt;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_dma_cnt <= '0;
            r_dbg_cnt <= '0;
        end else begin
            if (!bus.dma_valid || w_grant == OWN_DMA) r_dma_cnt <= '0;
            else if (r_dma_cnt < C_STARVE)            r_dma_cnt <= r_dma_cnt + 4'd1;
            if (!bus.dbg_valid || w_grant == OWN_DBG) r_dbg_cnt <= '0;
            else if (r_dbg_cnt < C_STARVE)            r_dbg_cnt <= r_dbg_cnt + 4'd1;
        end
    end

    // Reset in the response cycle drops the pending read data.
    assign bus.lsu_rsp_valid = !i_rst && (r_owner == OWN_LSU);
    assign bus.dma_rsp_valid = !i_rst && (r_owner == OWN_DMA);
    assign bus.dbg_rsp_valid = !i_rst && (r_owner == OWN_DBG);
    assign bus.rsp_data_lo   = bus.dccm_rd_data_lo;
    assign bus.rsp_data_hi   = bus.dccm_rd_data_hi;

`ifdef DCCM_PORT_ARB_PERF_EN
    logic [1:0]  w_nvalid;
    logic [15:0] r_perf_cnt;

    assign w_nvalid = {1'b0, bus.lsu_valid} + {1'b0, bus.dma_valid} + {1'b0, bus.dbg_valid};

    always_ff @(posedge i_clk) begin
        if (i_rst)                                     r_perf_cnt <= '0;
        else if (w_nvalid >= 2'd2 && r_perf_cnt != 16'hFFFF) r_perf_cnt <= r_perf_cnt + 16'd1;
    end

    assign o_perf_conflict_cnt = r_perf_cnt;
`endif
endmodule

// File: tb/tb_dccm_port_arb.sv
// tb/tb_dccm_port_arb.sv - self-checking bench for dccm_port_arb with a behavioural model
module tb_dccm_port_arb;
    localparam int AW = 16;
    localparam int DW = 39;
    localparam int SM = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    dccm_port_arb_if #(.DCCM_BITS(AW), .FDATA_WIDTH(DW)) bus ();

`ifdef DCCM_PORT_ARB_PERF_EN
    logic [15:0] perf;
`endif

    dccm_port_arb #(.DCCM_BITS(AW), .FDATA_WIDTH(DW), .STARVE_MAX(SM)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
`ifdef DCCM_PORT_ARB_PERF_EN
        ,
        .o_perf_conflict_cnt (perf)
`endif
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] rnd_data();
        logic [63:0] t;
        t = {$urandom(), $urandom()};
        return t[DW-1:0];
    endfunction

    // Model state: per-requester wait counts (1=LSU, 2=DMA, 3=DBG) and pending read owner.
    int m_wait [1:3];
    int m_rsp;
    int m_perf;
    initial begin
        m_wait[1] = 0; m_wait[2] = 0; m_wait[3] = 0;
        m_rsp = 0; m_perf = 0;
    end

    always @(negedge clk) begin : cmp
        logic            v  [1:3];
        logic            w  [1:3];
        logic [AW-1:0]   alo[1:3];
        logic [AW-1:0]   ahi[1:3];
        logic [DW-1:0]   d  [1:3];
        int              g;
        int              erd;
        int              nv;
        v[1] = bus.lsu_valid; w[1] = bus.lsu_wr; alo[1] = bus.lsu_addr_lo; ahi[1] = bus.lsu_addr_hi; d[1] = bus.lsu_wdata;
        v[2] = bus.dma_valid; w[2] = bus.dma_wr; alo[2] = bus.dma_addr;    ahi[2] = bus.dma_addr;    d[2] = bus.dma_wdata;
        v[3] = bus.dbg_valid; w[3] = bus.dbg_wr; alo[3] = bus.dbg_addr;    ahi[3] = bus.dbg_addr;    d[3] = bus.dbg_wdata;
        g = 0;
        if (!rst) begin
            if (v[2] && m_wait[2] == SM)      g = 2;
            else if (v[3] && m_wait[3] == SM) g = 3;
            else for (int k = 3; k >= 1; k--) if (v[k]) g = k;
        end
        erd = rst ? 0 : m_rsp;

        chk("lsu_ready", bus.lsu_ready, g == 1);
        chk("dma_ready", bus.dma_ready, g == 2);
        chk("dbg_ready", bus.dbg_ready, g == 3);
        chk("wren", bus.dccm_wren, g != 0 && w[g]);
        chk("rden", bus.dccm_rden, g != 0 && !w[g]);
        chk("wr_addr", bus.dccm_wr_addr, (g != 0 && w[g]) ? alo[g] : '0);
        chk("wr_data", bus.dccm_wr_data, (g != 0 && w[g]) ? d[g] : '0);
        chk("rd_addr_lo", bus.dccm_rd_addr_lo, (g != 0 && !w[g]) ? alo[g] : '0);
        chk("rd_addr_hi", bus.dccm_rd_addr_hi, (g != 0 && !w[g]) ? ahi[g] : '0);
        chk("lsu_rsp_valid", bus.lsu_rsp_valid, erd == 1);
        chk("dma_rsp_valid", bus.dma_rsp_valid, erd == 2);
        chk("dbg_rsp_valid", bus.dbg_rsp_valid, erd == 3);
        chk("rsp_data_lo", bus.rsp_data_lo, bus.dccm_rd_data_lo);
        chk("rsp_data_hi", bus.rsp_data_hi, bus.dccm_rd_data_hi);
`ifdef DCCM_PORT_ARB_PERF_EN
        chk("perf_cnt", perf, 16'(m_perf));
`endif

        nv = int'(v[1]) + int'(v[2]) + int'(v[3]);
        if (rst) begin
            m_wait[2] = 0; m_wait[3] = 0; m_rsp = 0; m_perf = 0;
        end else begin
            for (int k = 2; k <= 3; k++) begin
                if (!v[k] || g == k) m_wait[k] = 0;
                else if (m_wait[k] < SM) m_wait[k] = m_wait[k] + 1;
            end
            m_rsp = (g != 0 && !w[g]) ? g : 0;
            if (nv >= 2 && m_perf < 65535) m_perf = m_perf + 1;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.lsu_valid = 1'b0; bus.dma_valid = 1'b0; bus.dbg_valid = 1'b0;
    endtask

    task automatic lit();
        #2;
    endtask

    logic [DW-1:0] rd_lo_val;

    initial begin
        bus.lsu_valid = 0; bus.lsu_wr = 0; bus.lsu_addr_lo = '0; bus.lsu_addr_hi = '0; bus.lsu_wdata = '0;
        bus.dma_valid = 0; bus.dma_wr = 0; bus.dma_addr = '0; bus.dma_wdata = '0;
        bus.dbg_valid = 0; bus.dbg_wr = 0; bus.dbg_addr = '0; bus.dbg_wdata = '0;
        bus.dccm_rd_data_lo = '0; bus.dccm_rd_data_hi = '0;
        rst = 1'b1;
        repeat (3) step();
        lit();
        chk("reset_lsu_rsp", bus.lsu_rsp_valid, 1'b0);
        chk("reset_ready", {bus.lsu_ready, bus.dma_ready, bus.dbg_ready}, 3'b000);

        // LSU read lo=0x10 hi=0x14
        step(); rst = 1'b0;
        bus.lsu_valid = 1; bus.lsu_wr = 0; bus.lsu_addr_lo = 16'h0010; bus.lsu_addr_hi = 16'h0014;
        lit();
        chk("t1_lsu_ready", bus.lsu_ready, 1'b1);
        chk("t1_rden", bus.dccm_rden, 1'b1);
        chk("t1_rd_addr_lo", bus.dccm_rd_addr_lo, 16'h0010);
        chk("t1_rd_addr_hi", bus.dccm_rd_addr_hi, 16'h0014);
        step(); idle();
        rd_lo_val = 39'h12_3456_789A;
        bus.dccm_rd_data_lo = rd_lo_val;
        lit();
        chk("t1_lsu_rsp_valid", bus.lsu_rsp_valid, 1'b1);
        chk("t1_rsp_data_lo", bus.rsp_data_lo, 39'h12_3456_789A);

        // LSU and DMA both reading continuously: DMA forced in cycle 4
        for (int i = 0; i < 10; i++) begin
            step();
            bus.lsu_valid = 1; bus.lsu_wr = 0;
            bus.dma_valid = 1; bus.dma_wr = 0; bus.dma_addr = 16'h0040;
            lit();
            chk($sformatf("t2_lsu_ready_c%0d", i), bus.lsu_ready, (i != 4 && i != 9));
            chk($sformatf("t2_dma_ready_c%0d", i), bus.dma_ready, (i == 4 || i == 9));
        end
        step(); idle();

        // DMA write with DBG read in the same cycle
        step();
        bus.dma_valid = 1; bus.dma_wr = 1; bus.dma_addr = 16'h0100; bus.dma_wdata = 39'h1_2345_6789;
        bus.dbg_valid = 1; bus.dbg_wr = 0; bus.dbg_addr = 16'h0200;
        lit();
        chk("t3_dma_ready", bus.dma_ready, 1'b1);
        chk("t3_dbg_ready", bus.dbg_ready, 1'b0);
        chk("t3_wren", bus.dccm_wren, 1'b1);
        chk("t3_wr_addr", bus.dccm_wr_addr, 16'h0100);
        chk("t3_wr_data", bus.dccm_wr_data, 39'h1_2345_6789);
        step(); bus.dma_valid = 0;
        lit();
        chk("t3_dbg_ready2", bus.dbg_ready, 1'b1);
        chk("t3_dbg_rd_addr_hi", bus.dccm_rd_addr_hi, 16'h0200);
        chk("t3_no_rsp", bus.dma_rsp_valid, 1'b0);
        step(); idle();
        lit();
        chk("t3_dbg_rsp_valid", bus.dbg_rsp_valid, 1'b1);

        // Back-to-back reads LSU, DMA, DBG
        step(); idle(); bus.lsu_valid = 1; bus.lsu_wr = 0;
        step(); idle(); bus.dma_valid = 1; bus.dma_wr = 0;
        lit(); chk("t4_rsp_c1", {bus.lsu_rsp_valid, bus.dma_rsp_valid, bus.dbg_rsp_valid}, 3'b100);
        step(); idle(); bus.dbg_valid = 1; bus.dbg_wr = 0;
        lit(); chk("t4_rsp_c2", {bus.lsu_rsp_valid, bus.dma_rsp_valid, bus.dbg_rsp_valid}, 3'b010);
        step(); idle();
        lit(); chk("t4_rsp_c3", {bus.lsu_rsp_valid, bus.dma_rsp_valid, bus.dbg_rsp_valid}, 3'b001);

        // Read then reset: response suppressed
        step(); bus.lsu_valid = 1; bus.lsu_wr = 0;
        step(); rst = 1'b1; bus.dma_valid = 1; bus.dma_wr = 0;
        lit();
        chk("t5_rsp", {bus.lsu_rsp_valid, bus.dma_rsp_valid, bus.dbg_rsp_valid}, 3'b000);
        chk("t5_ready", {bus.lsu_ready, bus.dma_ready, bus.dbg_ready}, 3'b000);
        chk("t5_rden", bus.dccm_rden, 1'b0);
        step(); rst = 1'b0;
        lit();
        chk("t5_lsu_after_rst", bus.lsu_ready, 1'b1);
        chk("t5_no_rsp_after_rst", bus.lsu_rsp_valid, 1'b0);
        step(); idle();

`ifdef DCCM_PORT_ARB_PERF_EN
        step(); rst = 1'b1;
        step(); rst = 1'b0; bus.lsu_valid = 1; bus.dma_valid = 1;
        step(); bus.dbg_valid = 1;
        step(); bus.lsu_valid = 0;
        step(); idle();
        lit();
        chk("t6_perf_3", perf, 16'd3);
`endif

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            step();
            rst = ($urandom_range(0, 63) == 0);
            bus.lsu_valid = ($urandom_range(0, 9) < 6);
            bus.dma_valid = ($urandom_range(0, 9) < 5);
            bus.dbg_valid = ($urandom_range(0, 9) < 4);
            bus.lsu_wr = 1'($urandom()); bus.dma_wr = 1'($urandom()); bus.dbg_wr = 1'($urandom());
            bus.lsu_addr_lo = 16'($urandom()); bus.lsu_addr_hi = 16'($urandom());
            bus.dma_addr = 16'($urandom()); bus.dbg_addr = 16'($urandom());
            bus.lsu_wdata = rnd_data(); bus.dma_wdata = rnd_data(); bus.dbg_wdata = rnd_data();
            bus.dccm_rd_data_lo = rnd_data(); bus.dccm_rd_data_hi = rnd_data();
        end
        step(); idle(); rst = 1'b0;
        step();
        @(posedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/dccm_port_arb.md
Name: dccm_port_arb

Overview:
Arbiter/sequencer for the single DCCM array port. It shares the port between three requesters: LSU (DC stage), DMA slave and debug abstract-memory access. Fixed priority is LSU > DMA > DBG, with a starvation escape for DMA and DBG. It drives the DCCM wren/rden/address/data inputs and routes 1-cycle-latency read data back to the owning requester.

Parameters:
DCCM_BITS, 16, DCCM byte-address width
FDATA_WIDTH, 39, DCCM word width incl. ECC (32 data + 7 ECC)
STARVE_MAX, 4, consecutive denied cycles before a forced DMA/DBG grant (range 1..15)

Ports:
clk  in  1  core clock
rst  in  1  synchronous reset, active-high
lsu_valid  in  1  LSU access request
lsu_wr  in  1  1=write, 0=read
lsu_addr_lo  in  DCCM_BITS  LSU low-bank address
lsu_addr_hi  in  DCCM_BITS  LSU high-bank address (unaligned access)
lsu_wdata  in  FDATA_WIDTH  LSU write data
lsu_ready  out  1  LSU granted this cycle
dma_valid / dbg_valid  in  1  request
dma_wr / dbg_wr  in  1  1=write
dma_addr / dbg_addr  in  DCCM_BITS  address
dma_wdata / dbg_wdata  in  FDATA_WIDTH  write data
dma_ready / dbg_ready  out  1  granted this cycle
dccm_wren  out  1  to DCCM
dccm_rden  out  1  to DCCM
dccm_wr_addr  out  DCCM_BITS  to DCCM
dccm_rd_addr_lo  out  DCCM_BITS  to DCCM
dccm_rd_addr_hi  out  DCCM_BITS  to DCCM
dccm_wr_data  out  FDATA_WIDTH  to DCCM
dccm_rd_data_lo  in  FDATA_WIDTH  from DCCM, valid 1 cycle after rden
dccm_rd_data_hi  in  FDATA_WIDTH  from DCCM
lsu_rsp_valid / dma_rsp_valid / dbg_rsp_valid  out  1  read data valid for that requester
rsp_data_lo  out  FDATA_WIDTH  = dccm_rd_data_lo
rsp_data_hi  out  FDATA_WIDTH  = dccm_rd_data_hi

Behaviour:
- Grant is combinational, at most one ready per cycle. A transfer occurs on valid&ready. ready is never asserted without valid.
- Normal priority: LSU > DMA > DBG.
- Starvation counters dma_cnt and dbg_cnt are 4-bit:
  - increment when the requester is valid and not granted; saturate at STARVE_MAX.
  - clear on grant or when valid is low.
- Forced grant: if dma_cnt==STARVE_MAX and dma_valid, DMA wins over LSU. Otherwise, if dbg_cnt==STARVE_MAX and dbg_valid, DBG wins over LSU. DMA is checked before DBG when both are saturated.
- Memory drive on the granted requester:
  - dccm_wren = granted & wr; dccm_rden = granted & ~wr.
  - Write: dccm_wr_addr = requester address.
  - Read: dccm_rd_addr_lo = addr (LSU: addr_lo). dccm_rd_addr_hi = addr_hi for LSU, = addr for DMA/DBG.
  - Unused address/data outputs are driven 0.
  - No grant: wren=rden=0, all buses 0.
- Response pipeline: a 2-bit owner register (NONE/LSU/DMA/DBG) captures the read owner on each read grant, otherwise NONE. The matching *_rsp_valid is high in the following cycle. Back-to-back reads to different owners are supported every cycle.
- Writes produce no response.
- Reset values: owner=NONE, dma_cnt=dbg_cnt=0, all *_rsp_valid=0. rst asserted in the cycle after a read grant suppresses that response; the read is lost and the requester reissues.
- ready and the DCCM drives are 0 while rst=1.

Optional Feature:
DCCM_PORT_ARB_PERF_EN
- Defined: adds output perf_conflict_cnt [15:0]. The counter increments each cycle where ≥2 valids are high, saturates at 16'hFFFF and clears on rst.
- Undefined: the port is absent and no counter logic exists.

Test Plan:
- LSU read only, addr_lo=0x0010, addr_hi=0x0014 -> cycle0 lsu_ready=1, rden=1, rd_addr_lo=0x0010, rd_addr_hi=0x0014; cycle1 lsu_rsp_valid=1, rsp_data_lo=dccm_rd_data_lo.
- LSU and DMA both valid continuously, STARVE_MAX=4 -> LSU granted cycles 0-3, DMA granted cycle 4, dma_cnt=0 in cycle 5, LSU granted cycle 5.
- DMA write 0x0100 data 0x1_2345_6789 with DBG read 0x0200 in the same cycle -> DMA granted, wren=1, wr_addr=0x0100; DBG granted the next cycle; dbg_rsp_valid one cycle after that.
- Back-to-back reads LSU, DMA, DBG on three consecutive cycles -> lsu/dma/dbg_rsp_valid in cycles 1, 2, 3, exactly one high per cycle.
- Read granted in cycle 0, rst=1 in cycle 1 -> no rsp_valid in cycle 1, counters 0, ready=0.
- PERF_EN defined, 3 cycles with ≥2 valids -> perf_conflict_cnt=3. Preloaded at 0xFFFF -> stays 0xFFFF.
